// File: rtl/beta_multicycle_if.sv
// Memory port of the multicycle Beta core: one word transfer in flight at a time,
// completing on an edge where mem_req and mem_ready are both high.
interface beta_multicycle_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/beta_multicycle.sv
// Multicycle Beta CPU: FETCH/DECODE/EXEC/MEM/WB/HALT over a single shared memory port.
// Bus outputs are registered and loaded on the transition into FETCH or MEM.
module beta_multicycle #(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    beta_multicycle_if.master  mem,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc_out
);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t            state;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   a, b, y;
    logic [XLEN-1:0]   rf [32];

    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;

    logic [5:0]        op;
    logic [4:0]        rc, ra, rb, rbsel;
    logic [XLEN-1:0]   lit_x, ra_val, rb_val, alu_b, alu_y, ea;
    logic [ADDR_W-1:0] lit_a, br_off, ea_addr, jmp_t, br_t;
    logic              is_alu, is_ld, is_st, is_jmp, is_beq, is_bne, legal, taken;
    logic              rf_we;
    logic [XLEN-1:0]   rf_wd;

    assign op     = ir[31:26];
    assign rc     = ir[25:21];
    assign ra     = ir[20:16];
    assign rb     = ir[15:11];
    assign lit_x  = XLEN'($signed(ir[15:0]));
    assign lit_a  = ADDR_W'($signed(ir[15:0]));
    assign br_off = lit_a << 2;

    // ALU ops live at 0x2x (register) and 0x3x (literal); bit 4 picks the operand.
    always_comb begin
        is_alu = 1'b0;
        if (op[5]) begin
            case (op[3:0])
                4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA: is_alu = 1'b1;
                default:                                  is_alu = 1'b0;
            endcase
        end
    end

    assign is_ld  = (op == OP_LD);
    assign is_st  = (op == OP_ST);
    assign is_jmp = (op == OP_JMP);
    assign is_beq = (op == OP_BEQ);
    assign is_bne = (op == OP_BNE);
    assign legal  = is_alu | is_ld | is_st | is_jmp | is_beq | is_bne;

    // ST carries its data register in the rc field.
    assign rbsel  = is_st ? rc : rb;
    assign ra_val = (ra == 5'd31) ? '0 : rf[ra];
    assign rb_val = (rbsel == 5'd31) ? '0 : rf[rbsel];

    assign alu_b = op[4] ? lit_x : b;

    always_comb begin
        alu_y = '0;
        case (op[3:0])
            4'h0:    alu_y = a + alu_b;
            4'h1:    alu_y = a - alu_b;
            4'h4:    alu_y = XLEN'(a == alu_b);
            4'h5:    alu_y = XLEN'($signed(a) < $signed(alu_b));
            4'h8:    alu_y = a & alu_b;
            4'h9:    alu_y = a | alu_b;
            4'hA:    alu_y = a ^ alu_b;
            default: alu_y = '0;
        endcase
    end

    assign ea      = a + lit_x;
    assign ea_addr = ADDR_W'(ea) & WORD_MASK;
    assign jmp_t   = ADDR_W'(a) & WORD_MASK;
    assign taken   = is_beq ? (a == '0) : (a != '0);
    assign br_t    = taken ? pc + br_off : pc;

    // Single write port: link register in EXEC for control flow, result in WB.
    always_comb begin
        rf_we = 1'b0;
        rf_wd = '0;
        if (rst_n && rc != 5'd31) begin
            if (state == WB) begin
                rf_we = 1'b1;
                rf_wd = y;
            end else if (state == EXEC && (is_jmp || is_beq || is_bne)) begin
                rf_we = 1'b1;
                rf_wd = XLEN'(pc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rc] <= rf_wd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            halted  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= RESET_PC;
            wdata_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // Coming out of reset the request is not yet raised; raise it first.
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= pc;
                    end else if (mem.mem_ready) begin
                        ir    <= 32'(mem.mem_rdata);
                        pc    <= pc + PC_STEP;
                        req_q <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a <= ra_val;
                    b <= rb_val;
                    if (legal) begin
                        state <= EXEC;
                    end else begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_alu) begin
                        y     <= alu_y;
                        state <= WB;
                    end else if (is_ld || is_st) begin
                        y       <= ea;
                        req_q   <= 1'b1;
                        we_q    <= is_st;
                        addr_q  <= ea_addr;
                        wdata_q <= b;
                        state   <= MEM;
                    end else if (is_jmp) begin
                        pc     <= jmp_t;
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= jmp_t;
                        state  <= FETCH;
                    end else if (is_beq || is_bne) begin
                        pc     <= br_t;
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= br_t;
                        state  <= FETCH;
                    end else begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        we_q <= 1'b0;
                        if (is_st) begin
                            req_q  <= 1'b1;
                            addr_q <= pc;
                            state  <= FETCH;
                        end else begin
                            req_q <= 1'b0;
                            y     <= mem.mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                    addr_q <= pc;
                    state  <= FETCH;
                end
                HALT: begin
                    req_q  <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign pc_out        = pc;
endmodule

// File: tb/tb_beta_multicycle.sv
// Scoreboard bench for beta_multicycle: expected bus transfers are queued with the
// program, a negedge monitor compares every completed transfer and request stability.
module tb_beta_multicycle;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 16;

    localparam logic [5:0] ADDC = 6'h30, SUBC = 6'h31, CMPLTC = 6'h35, CMPEQ = 6'h24;
    localparam logic [5:0] SUB = 6'h21, CMPLT = 6'h25, ANDC = 6'h38, ORC = 6'h39, XOR = 6'h2A;
    localparam logic [5:0] LD = 6'h18, ST = 6'h19, JMP = 6'h1B, BEQ = 6'h1C, BNE = 6'h1D;

    typedef struct {
        bit          fetch;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          hold;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              halted;
    logic [ADDR_W-1:0] pc_out;

    beta_multicycle_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus();

    beta_multicycle #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem    (bus),
        .halted (halted),
        .pc_out (pc_out)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    txn_t        exp_q[$];
    int          fcyc[int];
    logic [31:0] mem  [256];
    logic [31:0] prog [256];
    int          dwait;
    int          wcnt;
    bit          load;
    int          cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    function automatic logic [31:0] encr(input logic [5:0] op, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'h0};
    endfunction

    task automatic p(input int addr, input logic [31:0] word);
        prog[addr >> 2] = word;
    endtask

    task automatic push(input bit f, input bit we, input int addr, input logic [31:0] d, input int h);
        txn_t t;
        t.fetch = f; t.we = we; t.addr = 16'(addr); t.wdata = d; t.hold = h;
        exp_q.push_back(t);
    endtask

    task automatic pf(input int addr);
        push(1'b1, 1'b0, addr, '0, 1);
    endtask

    task automatic pw(input int addr, input logic [31:0] d, input int h);
        push(1'b0, 1'b1, addr, d, h);
    endtask

    task automatic lat(input string name, input int a0, input int a1, input int exp);
        chk(name, (fcyc.exists(a0) && fcyc.exists(a1)) ? fcyc[a1] - fcyc[a0] : -1, exp);
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, halted, 1);
    endtask

    // Memory model: data region (>= 0x100) answers after dwait extra cycles.
    always_comb begin
        bus.mem_ready = rst_n && bus.mem_req &&
                        (wcnt >= ((bus.mem_addr >= 16'h0100) ? dwait : 0));
        bus.mem_rdata = mem[bus.mem_addr[9:2]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else if (bus.mem_ready && bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        if (!rst_n || !bus.mem_req || bus.mem_ready) wcnt <= 0;
        else                                           wcnt <= wcnt + 1;
    end

    // Monitor: pops one expectation per completed transfer.
    initial begin
        int          hold;
        bit          pend;
        logic [15:0] p_addr;
        bit          p_we;
        logic [31:0] p_wd;
        txn_t        t;
        hold = 0; pend = 1'b0; p_addr = '0; p_we = 1'b0; p_wd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
                pend = 1'b0;
            end else if (bus.mem_req) begin
                if (pend) begin
                    chk("hold_addr", bus.mem_addr, p_addr);
                    chk("hold_we", bus.mem_we, p_we);
                    if (p_we) chk("hold_wdata", bus.mem_wdata, p_wd);
                end
                hold++;
                if (bus.mem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: addr 0x%0h we %0b, expected no transfer",
                                 bus.mem_addr, bus.mem_we);
                    end else begin
                        t = exp_q.pop_front();
                        chk("xfer_addr", bus.mem_addr, t.addr);
                        chk("xfer_we", bus.mem_we, t.we);
                        if (t.we) chk("xfer_wdata", bus.mem_wdata, t.wdata);
                        chk("xfer_hold", hold, t.hold);
                        if (t.fetch) begin
                            chk("pc_out_at_fetch", pc_out, t.addr);
                            fcyc[int'(t.addr)] = cyc;
                        end
                    end
                    hold = 0;
                    pend = 1'b0;
                end else begin
                    pend   = 1'b1;
                    p_addr = bus.mem_addr;
                    p_we   = bus.mem_we;
                    p_wd   = bus.mem_wdata;
                end
            end else begin
                hold = 0;
                pend = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int n;
        int hcyc;
        checks = 0; errors = 0; dwait = 3; wcnt = 0; load = 1'b0; cyc = 0;
        for (int i = 0; i < 256; i++) prog[i] = '0;

        // Program A: ALU, memory with wait states, control flow, illegal opcode at 0x94.
        p('h00, enc (ADDC,   1, 31, 16'd5));
        p('h04, enc (SUBC,   2, 31, 16'd1));
        p('h08, enc (CMPLTC, 3,  2, 16'd0));
        p('h0C, encr(CMPEQ,  4,  2, 5'd2));
        p('h10, enc (ST,     1, 31, 16'h100));
        p('h14, enc (LD,     5, 31, 16'h100));
        p('h18, enc (ST,     2, 31, 16'h104));
        p('h1C, enc (ST,     3, 31, 16'h108));
        p('h20, enc (BNE,    6, 31, 16'hFFFF));
        p('h24, enc (ST,     4, 31, 16'h10C));
        p('h28, enc (ST,     5, 31, 16'h110));
        p('h2C, enc (ST,     6, 31, 16'h114));
        p('h30, enc (ADDC,   7, 31, 16'h53));
        p('h34, enc (JMP,    8,  7, 16'h0));
        p('h50, enc (ST,     8, 31, 16'h118));
        p('h54, enc (BEQ,    9, 31, 16'h0001));
        p('h5C, enc (ST,     9, 31, 16'h11C));
        p('h60, enc (BEQ,   10,  1, 16'hFFFF));
        p('h64, enc (ADDC,  31, 31, 16'd7));
        p('h68, encr(SUB,   11,  1, 5'd2));
        p('h6C, enc (ANDC,  12,  2, 16'h00F0));
        p('h70, enc (ORC,   13,  1, 16'hFFF0));
        p('h74, encr(XOR,   14, 13, 5'd2));
        p('h78, enc (ST,    31, 31, 16'h120));
        p('h7C, enc (ST,    10, 31, 16'h124));
        p('h80, enc (ST,    11, 31, 16'h128));
        p('h84, enc (ST,    12, 31, 16'h12C));
        p('h88, enc (ST,    14, 31, 16'h130));
        p('h8C, encr(CMPLT, 15,  1, 5'd2));
        p('h90, enc (ST,    15, 31, 16'h134));

        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc_out", pc_out, 16'h0000);

        pf('h00); pf('h04); pf('h08); pf('h0C); pf('h10);
        pw('h100, 32'd5, 4);
        pf('h14); push(1'b0, 1'b0, 'h100, '0, 4);
        pf('h18); pw('h104, 32'hFFFF_FFFF, 4);
        pf('h1C); pw('h108, 32'd1, 4);
        pf('h20); pf('h24); pw('h10C, 32'd1, 4);
        pf('h28); pw('h110, 32'd5, 4);
        pf('h2C); pw('h114, 32'h24, 4);
        pf('h30); pf('h34); pf('h50); pw('h118, 32'h38, 4);
        pf('h54); pf('h5C); pw('h11C, 32'h58, 4);
        pf('h60); pf('h64); pf('h68); pf('h6C); pf('h70); pf('h74);
        pf('h78); pw('h120, 32'h0, 4);
        pf('h7C); pw('h124, 32'h64, 4);
        pf('h80); pw('h128, 32'h6, 4);
        pf('h84); pw('h12C, 32'hF0, 4);
        pf('h88); pw('h130, 32'hA, 4);
        pf('h8C); pf('h90); pw('h134, 32'h0, 4);
        pf('h94);

        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first_fetch_req", bus.mem_req, 1);
        chk("first_fetch_addr", bus.mem_addr, 16'h0000);

        wait_halt("halt_reached_a", 3000);
        hcyc = cyc;
        chk("halt_timing", hcyc, fcyc.exists('h94) ? fcyc['h94] + 2 : -1);
        lat("lat_alu",    'h00, 'h04, 4);
        lat("lat_st_w3",  'h10, 'h14, 7);
        lat("lat_ld_w3",  'h14, 'h18, 8);
        lat("lat_bne_nt", 'h20, 'h24, 3);
        lat("lat_jmp",    'h34, 'h50, 3);
        lat("lat_beq_t",  'h54, 'h5C, 3);
        repeat (4) begin
            @(negedge clk);
            chk("halt_no_req", bus.mem_req, 0);
        end
        chk("halt_pc", pc_out, 16'h0098);
        chk("halt_sticky", halted, 1);
        chk("queue_empty_a", exp_q.size(), 0);

        // Reset aborts a stalled store; registers must survive it.
        @(posedge clk); #1 rst_n = 1'b0;
        p('h00, enc(ST, 2, 31, 16'h120));
        dwait = 20;
        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        pf('h00);
        @(negedge clk);
        chk("rst2_halted", halted, 0);
        chk("rst2_mem_req", bus.mem_req, 0);
        chk("rst2_pc_out", pc_out, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_store_seen", bus.mem_req && bus.mem_we, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_req", bus.mem_req, 0);
        chk("abort_no_write", mem['h120 >> 2], 32'h0);
        chk("abort_queue_empty", exp_q.size(), 0);

        p('h00, enc(ST, 1, 31, 16'h140));
        p('h04, enc(ST, 5, 31, 16'h144));
        p('h08, enc(ST, 8, 31, 16'h148));
        p('h0C, 32'h0);
        dwait = 0;
        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        pf('h00); pw('h140, 32'd5, 1);
        pf('h04); pw('h144, 32'd5, 1);
        pf('h08); pw('h148, 32'h38, 1);
        pf('h0C);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_halt("halt_reached_c", 500);
        chk("halt_pc_c", pc_out, 16'h0010);
        chk("queue_empty_c", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
